hazard_ctrl: RTL

- Central pipeline control unit for the 5-stage MIPS core.
- Generates the advance (enable) and flush controls consumed by the PC and by the IF/ID, ID/EX, EX/MEM and MEM/WB latches; its flush_IDEX output is the ID/EX latch's flush input.
- Holds taken-branch redirects and load-use bubbles pending until an ihit cycle lets the latches capture them.
- Freezes the pipeline on data-cache misses and after halt.

---
 rtl/hazard_ctrl_if.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if : status and control bundle between the MIPS pipeline datapath
//                  and the central hazard control unit.
//
// Status (datapath -> controller):
//   ihit, dhit, dmem_req           cache hits / MEM-stage access outstanding
//   id_rs, id_rt, id_use_rs/_rt    decode-stage source registers and usage
//   ex_memread, ex_rd              load in ID/EX and its destination register
//   branch_taken                   one-cycle taken-branch pulse from MEM
//   halt_wb                        halt instruction sitting in MEM/WB
// Control (controller -> datapath):
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en   stage advance enables
//   ifid_flush, flush_IDEX, exmem_flush           zero latch on advance
//   pc_redirect                                   PC loads held branch target
//   halted                                        pipeline permanently stopped
//   stall_cycles, flush_events                    performance counters
//
// Modports: master = hazard control unit, slave = datapath side.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
   logic        ihit;
   logic        dhit;
   logic        dmem_req;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        ex_memread;
   logic [4:0]  ex_rd;
   logic        branch_taken;
   logic        halt_wb;

   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exmem_en;
   logic        memwb_en;
   logic        ifid_flush;
   logic        flush_IDEX;
   logic        exmem_flush;
   logic        pc_redirect;
   logic        halted;
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;

   modport master (
      input  ihit, dhit, dmem_req, id_rs, id_rt, id_use_rs, id_use_rt,
             ex_memread, ex_rd, branch_taken, halt_wb,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, flush_IDEX, exmem_flush, pc_redirect, halted,
             stall_cycles, flush_events
   );

   modport slave (
      output ihit, dhit, dmem_req, id_rs, id_rt, id_use_rs, id_use_rt,
             ex_memread, ex_rd, branch_taken, halt_wb,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, flush_IDEX, exmem_flush, pc_redirect, halted,
             stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl : central pipeline control for the 5-stage MIPS core.
//
// Ports:
//   CLK   core clock
//   nRST  synchronous active-low reset, sampled on rising CLK
//   bus   hazard_ctrl_if.master (status in, stage enables/flushes/counters out)
//
// All control outputs are combinational from the FSM state and the current
// inputs (zero-cycle latency). Taken branches and dcache-miss-delayed branches
// are held pending until a cycle with ihit=1 and no freeze lets the latches
// capture the flush. Load-use hazards insert one ID/EX bubble per ihit cycle.
//
// Build option:
//   HAZARD_PERF_EN  defined   -> saturating stall_cycles / flush_events counters
//                   undefined -> both counter outputs tied to 32'h0
// -----------------------------------------------------------------------------
module hazard_ctrl (
   input  logic          CLK,
   input  logic          nRST,
   hazard_ctrl_if.master bus
);

   typedef enum logic [1:0] {RUN, DWAIT, REDIRECT, HALTED} state_t;

   state_t state;
   logic   redir_held;   // redirect seen before/while the dcache miss froze us

   logic freeze;
   logic loaduse;
   logic pend;
   logic apply_redirect;

   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, flush_idex, exmem_flush, pc_redirect, halted;

   always_comb begin
      freeze  = bus.dmem_req & ~bus.dhit;
      loaduse = bus.ex_memread & (bus.ex_rd != 5'd0) &
                ((bus.id_use_rs & (bus.id_rs == bus.ex_rd)) |
                 (bus.id_use_rt & (bus.id_rt == bus.ex_rd)));
      // A redirect remembered across a dcache miss is still pending once the
      // freeze lifts, so it flushes on the first usable ihit cycle.
      pend    = bus.branch_taken | (state == REDIRECT) |
                ((state == DWAIT) & redir_held);
      apply_redirect = nRST & (state != HALTED) & ~bus.halt_wb &
                       ~freeze & bus.ihit & pend;
   end

   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      flush_idex  = 1'b0;
      exmem_flush = 1'b0;
      pc_redirect = 1'b0;
      halted      = 1'b0;
      if (!nRST) begin
         halted = 1'b0;
      end else if ((state == HALTED) || bus.halt_wb) begin
         // halt is older than any branch behind it, so it wins over a flush
         halted = (state == HALTED);
      end else if (freeze || !bus.ihit) begin
         halted = 1'b0;
      end else if (pend) begin
         pc_en       = 1'b1;
         ifid_en     = 1'b1;
         idex_en     = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
         ifid_flush  = 1'b1;
         flush_idex  = 1'b1;
         exmem_flush = 1'b1;
         pc_redirect = 1'b1;
      end else if (loaduse) begin
         // hold PC and IF/ID, push a bubble into ID/EX, let the load proceed
         idex_en     = 1'b1;
         flush_idex  = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
      end else begin
         pc_en       = 1'b1;
         ifid_en     = 1'b1;
         idex_en     = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= RUN;
         redir_held <= 1'b0;
      end else if (state == HALTED) begin
         state      <= HALTED;
      end else if (bus.halt_wb && !freeze) begin
         state      <= HALTED;
      end else if (freeze) begin
         state      <= DWAIT;
         redir_held <= pend;
      end else if (apply_redirect) begin
         state      <= RUN;
         redir_held <= 1'b0;
      end else if (pend) begin
         state      <= REDIRECT;
         redir_held <= 1'b0;
      end else begin
         state      <= RUN;
         redir_held <= 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if ((state != HALTED) && !pc_en) stall_cnt <= sat_inc(stall_cnt);
         if (apply_redirect)              flush_cnt <= sat_inc(flush_cnt);
      end
   end

   assign bus.stall_cycles = nRST ? stall_cnt : 32'd0;
   assign bus.flush_events = nRST ? flush_cnt : 32'd0;
`else
   assign bus.stall_cycles = 32'h0;
   assign bus.flush_events = 32'h0;
`endif

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.idex_en     = idex_en;
   assign bus.exmem_en    = exmem_en;
   assign bus.memwb_en    = memwb_en;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.flush_IDEX  = flush_idex;
   assign bus.exmem_flush = exmem_flush;
   assign bus.pc_redirect = pc_redirect;
   assign bus.halted      = halted;

endmodule
